// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter:
// arbiter states and the posted-write buffer entry.
package mem_port_arbiter_pkg;

  localparam int P_XLEN       = 64;
  localparam int P_IALIGN     = 32;
  localparam int P_WBUF_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    D_RD,
    WB_DRAIN,
    FENCE_WAIT
  } arb_state_t;

  typedef struct packed {
    logic [P_XLEN-1:0] addr;
    logic [P_XLEN-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side signals of the arbiter.
// master: the arbiter, slave: pipeline plus memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN   = P_XLEN,
  parameter int IALIGN = P_IALIGN
);

  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic [IALIGN-1:0] if_rdata;
  logic              if_valid;
  logic              d_re;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN-1:0]   d_rdata;
  logic              d_done;
  logic              fence_req;
  logic              fence_done;
  logic              stall;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  modport master (
    input  if_req, if_addr,
    input  d_re, d_we, d_addr, d_wdata,
    input  fence_req,
    input  mem_rdata, mem_ready,
    output if_rdata, if_valid,
    output d_rdata, d_done,
    output fence_done, stall,
    output mem_addr, mem_wdata,
    output mem_re, mem_we
  );

  modport slave (
    output if_req, if_addr,
    output d_re, d_we, d_addr, d_wdata,
    output fence_req,
    output mem_rdata, mem_ready,
    input  if_rdata, if_valid,
    input  d_rdata, d_done,
    input  fence_done, stall,
    input  mem_addr, mem_wdata,
    input  mem_re, mem_we
  );

endinterface

// File: rtl/mem_port_arbiter_wbuf_fifo.sv
// Posted write buffer: circular FIFO of addr/data
// entries with head and head+1 read ports.
module wbuf_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter  int DEPTH = P_WBUF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  wbuf_entry_t din_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o,
  output wbuf_entry_t head_o,
  output wbuf_entry_t head_nxt_o
);

  wbuf_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o     = cnt_q == (AW+1)'(DEPTH);
  assign empty_o    = cnt_q == '0;
  assign count_o    = cnt_q;
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign rd_nxt     = rd_ptr_q + AW'(1);
  assign head_o     = mem_q[rd_ptr_q];
  assign head_nxt_o = mem_q[rd_nxt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_nxt;
      if (do_push && !do_pop)
        cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  // contents need no reset: the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data traffic,
// with a posted write buffer and FENCE ordering.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN       = P_XLEN,
  parameter int IALIGN     = P_IALIGN,
  parameter int WBUF_DEPTH = P_WBUF_DEPTH
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam int AW = $clog2(WBUF_DEPTH);

  arb_state_t        state_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [IALIGN-1:0] if_rdata_q;
  logic              if_valid_q;
  logic [XLEN-1:0]   d_rdata_q;
  logic              d_done_q;
  logic              fence_done_q;
  logic              acc_q;
  logic              full_entry_q;

  wbuf_entry_t wb_din;
  wbuf_entry_t wb_head;
  wbuf_entry_t wb_nxt;
  logic        wb_full;
  logic        wb_empty;
  logic [AW:0] wb_cnt;
  logic        push;
  logic        pop;
  logic        stall;
  logic        d_pend;
  logic        f_pend;
  logic        i_pend;
  logic        rdy;
  logic        stay;

  assign wb_din = '{addr: bus.d_addr, data: bus.d_wdata};
  assign rdy    = bus.mem_ready;
  assign push   = bus.d_we & ~acc_q & ~wb_full;
  assign pop    = (state_q == WB_DRAIN) & rdy;

  // a request whose done pulse is showing belongs to
  // the instruction now leaving, so it is not re-granted
  assign d_pend = bus.d_re & ~d_done_q;
  assign f_pend = bus.fence_req & ~fence_done_q;
  assign i_pend = bus.if_req & ~if_valid_q;

  assign stall = (bus.d_re & ~d_done_q)
               | (bus.d_we & ~acc_q)
               | (bus.fence_req & ~fence_done_q);

  assign stay = (wb_cnt > (AW+1)'(1))
              & (f_pend | d_pend | full_entry_q);

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .din_i     (wb_din),
    .pop_i     (pop),
    .full_o    (wb_full),
    .empty_o   (wb_empty),
    .count_o   (wb_cnt),
    .head_o    (wb_head),
    .head_nxt_o(wb_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      d_rdata_q    <= '0;
      d_done_q     <= 1'b0;
      fence_done_q <= 1'b0;
      acc_q        <= 1'b0;
      full_entry_q <= 1'b0;
    end else begin
      if_valid_q   <= 1'b0;
      d_done_q     <= push;
      fence_done_q <= 1'b0;
      if (push)
        acc_q <= 1'b1;
      else if (!bus.d_we || !stall)
        acc_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (d_pend && wb_empty) begin
            state_q    <= D_RD;
            mem_re_q   <= 1'b1;
            mem_addr_q <= bus.d_addr;
          end else if (f_pend && wb_empty) begin
            state_q <= FENCE_WAIT;
          end else if (wb_full || f_pend || d_pend
                       || (!i_pend && !wb_empty)) begin
            state_q      <= WB_DRAIN;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= wb_head.addr;
            mem_wdata_q  <= wb_head.data;
            full_entry_q <= wb_full;
          end else if (i_pend) begin
            state_q    <= IF_RD;
            mem_re_q   <= 1'b1;
            mem_addr_q <= bus.if_addr;
          end
        end
        IF_RD: begin
          if (rdy) begin
            state_q    <= IDLE;
            mem_re_q   <= 1'b0;
            if_rdata_q <= bus.mem_rdata[IALIGN-1:0];
            if_valid_q <= 1'b1;
          end
        end
        D_RD: begin
          if (rdy) begin
            state_q   <= IDLE;
            mem_re_q  <= 1'b0;
            d_rdata_q <= bus.mem_rdata;
            d_done_q  <= 1'b1;
          end
        end
        WB_DRAIN: begin
          if (rdy) begin
            if (stay) begin
              mem_addr_q  <= wb_nxt.addr;
              mem_wdata_q <= wb_nxt.data;
            end else begin
              state_q  <= IDLE;
              mem_we_q <= 1'b0;
            end
          end
        end
        FENCE_WAIT: begin
          state_q      <= IDLE;
          fence_done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_done     = d_done_q;
  assign bus.fence_done = fence_done_q;
  assign bus.stall      = rst & stall;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch and execute-stage data loads/stores.
- Holds a posted write buffer so stores do not stall the pipeline unless the buffer is full.
- Arbitrates fetch vs. data traffic, drains buffered writes, and implements FENCE ordering.
- Generates the pipeline stall consumed by the fetch/decode/execute pipeline registers.

Parameters:
- XLEN, 64, data/address width (matches MAX_XLEN_INDEX+1).
- IALIGN, 32, instruction word width.
- WBUF_DEPTH, 4, posted write buffer entries (power of two, >=2).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  fetch requests instruction at if_addr.
- if_addr  in  XLEN  fetch address (PC).
- if_rdata  out  IALIGN  fetched instruction, registered.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- d_re  in  1  execute-stage load request (level, held until d_done).
- d_we  in  1  execute-stage store request (level, held until d_done).
- d_addr  in  XLEN  load/store address.
- d_wdata  in  XLEN  store data.
- d_rdata  out  XLEN  load data, registered.
- d_done  out  1  one-cycle pulse: load data valid or store accepted.
- fence_req  in  1  FENCE in execute (level, held until fence_done).
- fence_done  out  1  one-cycle pulse: all prior writes drained.
- stall  out  1  pipeline stall.
- mem_addr  out  XLEN  external address.
- mem_wdata  out  XLEN  external write data.
- mem_re  out  1  external read strobe.
- mem_we  out  1  external write strobe.
- mem_rdata  in  XLEN  external read data.
- mem_ready  in  1  one-cycle pulse: current access complete.

Behaviour:
- Reset (rst=0, async): state=IDLE; buffer empty (wr_ptr=rd_ptr=0, count=0); all outputs 0.
- States: IDLE, IF_RD, D_RD, WB_DRAIN, FENCE_WAIT.
- IDLE grant priority, evaluated each cycle:
  1. d_re with buffer empty -> D_RD.
  2. Buffer full, fence_req, or d_re with buffer non-empty -> WB_DRAIN.
  3. if_req -> IF_RD.
  4. Buffer non-empty -> WB_DRAIN (opportunistic drain).
- Loads never bypass buffered stores: a pending d_re forces the buffer to drain fully before D_RD is entered. No forwarding.
- Store acceptance: d_we with count<WBUF_DEPTH is written to buffer at wr_ptr on the rising edge in any state. d_done pulses the next cycle. Only one acceptance per d_we assertion; an internal flag blocks re-acceptance until d_we drops or the pipeline advances.
- Full buffer: d_we is held off, stall=1, d_done=0 until an entry retires.
- IF_RD/D_RD: mem_re=1; mem_addr stable for the whole access. On mem_ready, capture mem_rdata, pulse if_valid/d_done the next cycle, return to IDLE. if_rdata takes bits [IALIGN-1:0].
- WB_DRAIN: mem_we=1 with the head entry's addr/data. On mem_ready: rd_ptr++, count--.
  - Stays in WB_DRAIN while entries remain and (fence_req or d_re is pending or the buffer was full on entry).
  - Otherwise returns to IDLE.
- Simultaneous push and retire in one cycle: count unchanged; both pointers advance. Pointers wrap modulo WBUF_DEPTH.
- FENCE: when fence_req and count==0, go to FENCE_WAIT, pulse fence_done for one cycle, then return to IDLE. A fence with an already-empty buffer completes in 2 cycles.
- stall = (d_re & ~d_done) | (d_we & ~accepted) | (fence_req & ~fence_done).
- mem_ready in IDLE or FENCE_WAIT is ignored.
- mem_re and mem_we are never both 1 in the same cycle.
- Reset mid-access: the access is aborted, buffer contents are discarded, and outputs return to 0 immediately.

Decomposition:
- Shared package (rv64i package/header): arb_state_t enum (IDLE, IF_RD, D_RD, WB_DRAIN, FENCE_WAIT); wbuf_entry_t struct {addr, data}; WBUF_DEPTH default.
- One sub-module: wbuf_fifo.
  - Synchronous-write, registered-output FIFO.
  - Ports: push, pop, full, empty, count, head entry.
  - Same clk/rst convention.

Test Plan:
- Reset release, if_req=1, addr 0x1000, mem_ready after 2 cycles with 0x00500093 -> mem_re=1 with mem_addr=0x1000 for 2 cycles; if_valid pulse with if_rdata=0x00500093; stall=0.
- Four stores (addr 0x2000..0x2018) back-to-back, mem_ready held low -> four d_done pulses, count=4. A fifth d_we gives stall=1 and no d_done until the first mem_ready; then it is accepted.
- Store 0x3000<=0xDEAD then load 0x3000 -> mem_we with 0x3000/0xDEAD precedes mem_re 0x3000; d_rdata=mem_rdata; stall held until d_done.
- fence_req with 2 buffered stores -> both writes issued in FIFO order, then exactly one fence_done pulse; with empty buffer, fence_done 2 cycles after fence_req.
- if_req and d_re asserted in the same cycle, buffer empty -> D_RD granted first; IF_RD follows the load's completion.
- rst=0 asserted mid-WB_DRAIN with 3 entries -> all outputs 0 immediately; after release, count=0 and no mem_we is issued.
